// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and defaults for the shared register arbiter and its picker.
package shared_reg_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_W        = 8;
  localparam int DEF_MAX_HOLD = 4;

  // Index width that stays at least one bit for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping,
// with an optional exclude mask; returns one-hot grant, its index and valid.
module rr_pick
  import shared_reg_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = idx_w(DEF_N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     excl,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [N-1:0] cand;

  assign cand = req & ~excl;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && cand[(int'(ptr) + i) % N]) begin
        valid                      = 1'b1;
        gnt[(int'(ptr) + i) % N]   = 1'b1;
        idx                        = IDX_W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner arbitration for one shared W-bit register with lock and
// starvation-bounding hold counter. Define SHARED_REG_ASSERT_EN for checks.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int W        = DEF_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           lock,
  input  logic [N-1:0]           wen,
  input  logic [N*W-1:0]         Din,
  output logic [N-1:0]           gnt,
  output logic [idx_w(N)-1:0]    owner,
  output logic [W-1:0]           Dout,
  output logic                   upd
);

  localparam int IDX_W  = idx_w(N);
  localparam int HOLD_W = idx_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [W-1:0]       dout_q, dout_d;
  logic               upd_q, upd_d;

  logic               owned;
  logic [N-1:0]       owner_oh;
  logic               other_req;
  logic               forced;
  logic               release_now;
  logic               start_grant;
  logic [IDX_W-1:0]   ptr_after;
  logic [IDX_W-1:0]   pick_ptr;
  logic [N-1:0]       pick_excl;
  logic [N-1:0]       pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  assign owned       = (state_q == ST_OWNED);
  assign owner_oh    = N'(1) << owner_q;
  assign other_req   = |(req & ~owner_oh);
  assign forced      = owned && (hold_q == HOLD_MAX) && other_req;
  assign release_now = owned && (!lock[owner_q] || forced);
  assign ptr_after   = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + IDX_W'(1);
  // The releasing owner sits last in the wrap from ptr_after, so it only
  // wins again when nobody else asks; a forced release excludes it outright.
  assign pick_ptr    = owned ? ptr_after : ptr_q;
  assign pick_excl   = forced ? owner_oh : '0;
  assign start_grant = pick_valid && (!owned || release_now);

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      dout_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      upd_q   <= upd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_valid) state_d = ST_OWNED;
      ST_OWNED: if (release_now && !pick_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    dout_d  = dout_q;
    upd_d   = 1'b0;

    if (owned && wen[owner_q]) begin
      dout_d = Din[int'(owner_q)*W +: W];
      upd_d  = 1'b1;
    end

    if (release_now) ptr_d = ptr_after;

    if (start_grant) begin
      gnt_d   = pick_gnt;
      owner_d = pick_idx;
      hold_d  = '0;
    end else if (release_now) begin
      gnt_d = '0;
    end else if (owned && hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign Dout  = dout_q;
  assign upd   = upd_q;

`ifdef SHARED_REG_ASSERT_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert ($onehot0(gnt_q));
      assert (32'(hold_q) < MAX_HOLD);
      assert ((dout_d == dout_q) || upd_d);
      if (owned) assert (gnt_q == owner_oh);
      else       assert (gnt_q == '0);
      if (owned && other_req && hold_q == HOLD_MAX) assert (release_now);
    end
  end
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomized and directed bench for shared_reg_arbiter against an owner-level
// model that tracks owned-cycle counts instead of a saturating hold counter.
module tb_shared_reg_arbiter;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_HOLD = 4;
  localparam int IDX_W    = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic [N-1:0]     req;
  logic [N-1:0]     lock;
  logic [N-1:0]     wen;
  logic [N*W-1:0]   Din;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] owner;
  logic [W-1:0]     Dout;
  logic             upd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: current owner (-1 idle), last owner shown on the port,
  // round-robin start, owned cycles so far, register and update flag.
  int       m_owner = -1;
  int       m_last  = 0;
  int       m_ptr   = 0;
  int       m_cyc   = 0;
  logic [W-1:0] m_dout = '0;
  logic     m_upd = 1'b0;

  shared_reg_arbiter #(
    .N        (N),
    .W        (W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .req   (req),
    .lock  (lock),
    .wen   (wen),
    .Din   (Din),
    .gnt   (gnt),
    .owner (owner),
    .Dout  (Dout),
    .upd   (upd)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int scan(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int k;
    int o;
    bit others;
    if (RST) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_cyc = 0; m_dout = '0; m_upd = 1'b0;
      return;
    end
    m_upd = 1'b0;
    if (m_owner < 0) begin
      k = scan(req, m_ptr);
      if (k >= 0) begin
        m_owner = k; m_last = k; m_cyc = 1;
      end
    end else begin
      o = m_owner;
      if (wen[o]) begin
        m_dout = Din[o*W +: W];
        m_upd  = 1'b1;
      end
      others = 1'b0;
      for (int j = 0; j < N; j++) if (j != o && req[j]) others = 1'b1;
      if (!lock[o] || (others && m_cyc >= MAX_HOLD)) begin
        m_ptr = (o + 1) % N;
        k = scan(req, m_ptr);
        if (k >= 0) begin
          m_owner = k; m_last = k; m_cyc = 1;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_cyc++;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_gnt;
    model_edge();
    @(posedge CLK);
    #1;
    cyc++;
    exp_gnt = (m_owner < 0) ? '0 : N'(1) << m_owner;
    $display("cyc %0d rst=%b req=%b lock=%b wen=%b gnt=%b owner=%0d dout=%h upd=%b",
             cyc, RST, req, lock, wen, gnt, owner, Dout, upd);
    chk("gnt",   32'(gnt),   32'(exp_gnt));
    chk("owner", 32'(owner), 32'(m_last));
    chk("dout",  32'(Dout),  32'(m_dout));
    chk("upd",   32'(upd),   32'(m_upd));
  endtask

  task automatic do_reset();
    RST = 1'b1; req = '0; lock = '0; wen = '0; Din = '0;
    step();
    RST = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_gnt",   32'(gnt),   32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_dout",  32'(Dout),  32'h0);
    chk("rst_upd",   32'(upd),   32'h0);

    // Single requester, one write, then release to idle.
    req = 4'b0001; step();
    chk("t1_gnt", 32'(gnt), 32'h1);
    req = '0; wen = 4'b0001; Din = 32'h0000_00A5; step();
    chk("t1_dout", 32'(Dout), 32'hA5);
    chk("t1_upd",  32'(upd),  32'h1);
    chk("t1_idle", 32'(gnt),  32'h0);
    wen = '0; step();
    chk("t1_upd_off", 32'(upd), 32'h0);

    // All requesting, no lock: strict rotation without idle gaps.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_rot", 32'(gnt), 32'(N'(1) << (i % N)));
    end

    // Locked owner 2 forced out after MAX_HOLD cycles by req[0].
    do_reset();
    req = 4'b0100; lock = 4'b0100; step();
    chk("t3_gnt2", 32'(gnt), 32'h4);
    req = 4'b0001;
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      step();
      chk("t3_hold", 32'(gnt), 32'h4);
    end
    step();
    chk("t3_handover", 32'(gnt), 32'h1);

    // Locked owner without contention keeps ownership indefinitely.
    do_reset();
    req = 4'b0100; lock = 4'b0100; step();
    req = '0;
    for (int i = 0; i < 22; i++) begin
      step();
      chk("t3_persist", 32'(gnt), 32'h4);
    end

    // Non-owner write ignored, owner write accepted.
    do_reset();
    req = 4'b0010; lock = 4'b0010; step();
    chk("t4_gnt1", 32'(gnt), 32'h2);
    req = '0; wen = 4'b1000; Din = 32'h5500_0000; step();
    chk("t4_ignore_dout", 32'(Dout), 32'h0);
    chk("t4_ignore_upd",  32'(upd),  32'h0);
    wen = 4'b1010; Din = 32'h5500_3C00; step();
    chk("t4_dout", 32'(Dout), 32'h3C);
    chk("t4_upd",  32'(upd),  32'h1);

    // Reset mid-ownership with a write pending; pointer restarts at 0.
    RST = 1'b1; wen = 4'b0010; Din = 32'h0000_7700; step();
    chk("t5_gnt",  32'(gnt),  32'h0);
    chk("t5_dout", 32'(Dout), 32'h0);
    chk("t5_upd",  32'(upd),  32'h0);
    RST = 1'b0; wen = '0; lock = '0; req = 4'b1000; step();
    chk("t5_wrap", 32'(gnt), 32'h8);

    // Random traffic: mixed densities, mostly-locked phases, rare resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      RST  = ($urandom_range(0, 249) == 0);
      req  = ($urandom_range(0, 1) == 0) ? N'($urandom & $urandom) : N'($urandom);
      lock = ((i / 200) % 2 == 1) ? ~N'($urandom & $urandom & $urandom) : N'($urandom);
      wen  = N'($urandom);
      Din  = 32'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
